// File: rtl/instr_fetch_pair_pkg.sv
// Shared constants and types for the paired instruction fetch stage.
// Filler words, the stop opcode and the fetch state encoding live here.
package instr_fetch_pair_pkg;

  localparam logic [0:31] NOP_WORD  = 32'h40200000;
  localparam logic [0:31] LNOP_WORD = 32'h00200000;
  localparam logic [0:10] STOP_OPC  = 11'b0;

  typedef logic [0:31] word_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  function automatic logic is_stop(input word_t w);
    return w[0:10] == STOP_OPC;
  endfunction

endpackage

// File: rtl/instr_store.sv
// Instruction store: one synchronous write port, two asynchronous reads.
// The second read port returns the word after raddr_i, wrapping at the top.
module instr_store #(
  parameter int PC_W = 10
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic [0:PC_W-1] waddr_i,
  input  logic [0:31]    wdata_i,
  input  logic [0:PC_W-1] raddr_i,
  output logic [0:31]    rdata0_o,
  output logic [0:31]    rdata1_o
);

  localparam int DEPTH = 2 ** PC_W;

  logic [0:31]     mem_q [0:DEPTH-1];
  logic [0:PC_W-1] raddr1;

  assign raddr1 = raddr_i + PC_W'(1);

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = mem_q[raddr_i];
  assign rdata1_o = mem_q[raddr1];

endmodule

// File: rtl/instr_fetch_pair.sv
// Paired fetch stage: registered instruction pair, one-entry replay on
// late stall, branch redirect, odd-aligned single issue, halt on stop.
module instr_fetch_pair
  import instr_fetch_pair_pkg::*;
#(
  parameter int          PC_W      = 10,
  parameter logic [0:31] NOP_WORD  = instr_fetch_pair_pkg::NOP_WORD,
  parameter logic [0:31] LNOP_WORD = instr_fetch_pair_pkg::LNOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_wr_en,
  input  logic [0:PC_W-1] imem_wr_addr,
  input  logic [0:31]     imem_wr_data,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [0:PC_W-1] branch_target,
  output logic [0:31]     instruction_out1,
  output logic [0:31]     instruction_out2,
  output logic            find_nop,
  output logic [0:PC_W-1] PC_out,
  output logic            halted
);

  fetch_state_e    state_q;
  logic [0:PC_W-1] pc_q;
  logic            stall_seen_q;

  word_t           out1_q;
  word_t           out2_q;
  logic            fn_q;
  logic [0:PC_W-1] pc_out_q;
  logic            halted_q;

  word_t           rp_out1_q;
  word_t           rp_out2_q;
  logic            rp_fn_q;
  logic [0:PC_W-1] rp_pc_q;

  word_t           rd0;
  word_t           rd1;
  logic            pc_odd;
  logic            stop0;
  logic            stop1;
  logic            single_d;
  logic            halt_d;
  logic [0:PC_W-1] pc_d;

  instr_store #(
    .PC_W (PC_W)
  ) u_store (
    .clk_i    (clk),
    .we_i     (imem_wr_en),
    .waddr_i  (imem_wr_addr),
    .wdata_i  (imem_wr_data),
    .raddr_i  (pc_q),
    .rdata0_o (rd0),
    .rdata1_o (rd1)
  );

  assign pc_odd   = pc_q[PC_W-1];
  assign stop0    = is_stop(rd0);
  assign stop1    = is_stop(rd1);
  assign single_d = pc_odd | stop0;
  // Slot 2 only counts as a stop when it is actually issued.
  assign halt_d   = stop0 | (~pc_odd & stop1);
  assign pc_d     = pc_odd ? pc_q + PC_W'(1) : pc_q + PC_W'(2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= '0;
      stall_seen_q <= 1'b0;
      out1_q       <= NOP_WORD;
      out2_q       <= LNOP_WORD;
      fn_q         <= 1'b0;
      pc_out_q     <= '0;
      halted_q     <= 1'b0;
      rp_out1_q    <= NOP_WORD;
      rp_out2_q    <= LNOP_WORD;
      rp_fn_q      <= 1'b0;
      rp_pc_q      <= '0;
    end else if (state_q == HALT) begin
      out1_q   <= NOP_WORD;
      out2_q   <= LNOP_WORD;
      fn_q     <= 1'b0;
      halted_q <= 1'b1;
    end else if (branch_taken) begin
      pc_q         <= branch_target;
      out1_q       <= NOP_WORD;
      out2_q       <= LNOP_WORD;
      fn_q         <= 1'b0;
      stall_seen_q <= 1'b0;
    end else if (stall) begin
      // The stall refers to the pair already presented; replay the one
      // before it and re-fetch the squashed pair afterwards.
      if (!stall_seen_q) begin
        out1_q       <= rp_out1_q;
        out2_q       <= rp_out2_q;
        fn_q         <= rp_fn_q;
        pc_out_q     <= rp_pc_q;
        pc_q         <= pc_out_q;
        stall_seen_q <= 1'b1;
      end
    end else begin
      rp_out1_q    <= out1_q;
      rp_out2_q    <= out2_q;
      rp_fn_q      <= fn_q;
      rp_pc_q      <= pc_out_q;
      out1_q       <= rd0;
      out2_q       <= single_d ? rd0 : rd1;
      fn_q         <= single_d;
      pc_out_q     <= pc_q;
      stall_seen_q <= 1'b0;
      if (halt_d) begin
        state_q <= HALT;
      end else begin
        pc_q <= pc_d;
      end
    end
  end

  assign instruction_out1 = out1_q;
  assign instruction_out2 = out2_q;
  assign find_nop         = fn_q;
  assign PC_out           = pc_out_q;
  assign halted           = halted_q;

endmodule
